// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath (R-type, lw, sw, beq, j, addi).
// All control outputs decode from the current state and are held at zero while reset is high.
module multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Opcode is only consulted in Decode and MemAddr; every other state has a fixed successor.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADDR: begin
        if (Opcode == OP_LW)      state_d = S_MEMRD;
        else if (Opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXEC:    state_d = S_RWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    State       = 4'd0;
    // Reset gates every output so no architectural write can slip out mid-reset.
    if (!reset) begin
      State = state_q;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = 1'b1;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADDR, S_ADDI_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDI_WB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a per-instruction state-sequence model,
// plus directed reset-abort, illegal-opcode and back-to-back addi scenarios.
module tb_multicycle_control;

  logic       clock;
  logic       reset;
  logic [5:0] Opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];
  int rw_stamps[$];

  multicycle_control dut (
    .clock(clock), .reset(reset), .Opcode(Opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .State(State)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Output bundle order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource
  function automatic logic [15:0] obs_outs();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  // Control word listed for each named step of an instruction.
  function automatic logic [15:0] exp_outs(input logic [3:0] s);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      4'd0:  begin mr = 1; irw = 1; asb = 2'b01; pcw = 1; end
      4'd1:  asb = 2'b11;
      4'd2,
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, pcs};
  endfunction

  // Reference model: the walk of state codes one instruction takes, Fetch first.
  function automatic void push_expected(input logic [5:0] op);
    case (op)
      6'b100011: exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'b101011: exp_q = '{4'd0, 4'd1, 4'd2, 4'd5};
      6'b000000: exp_q = '{4'd0, 4'd1, 4'd6, 4'd7};
      6'b001000: exp_q = '{4'd0, 4'd1, 4'd10, 4'd11};
      6'b000100: exp_q = '{4'd0, 4'd1, 4'd8};
      6'b000010: exp_q = '{4'd0, 4'd1, 4'd9};
      default:   exp_q = '{4'd0, 4'd1};
    endcase
  endfunction

  function automatic int exp_regwrites(input logic [5:0] op);
    return (op == 6'b100011 || op == 6'b000000 || op == 6'b001000) ? 1 : 0;
  endfunction

  // ---------------- driver ----------------
  // Entered at a negedge with the DUT in Fetch; returns at the negedge of the next Fetch.
  // abort_at >= 0 asserts reset at that step of the instruction.
  task automatic run_instr(input logic [5:0] op, input int abort_at);
    int idx;
    int rw_cnt;
    int exp_len;
    logic [3:0] s;
    idx = 0;
    rw_cnt = 0;
    push_expected(op);
    exp_len = exp_q.size();
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      if (abort_at == idx) begin
        exp_q.delete();
        reset = 1'b1;
        Opcode = 6'($urandom);
        #1;
        check_val("rst_state", 32'(State), 32'd0);
        check_val("rst_outs", 32'(obs_outs()), 32'd0);
        repeat (2) begin
          @(negedge clock); cyc++;
          Opcode = 6'($urandom);
          #1;
          check_val("rst_hold_state", 32'(State), 32'd0);
          check_val("rst_hold_outs", 32'(obs_outs()), 32'd0);
        end
        reset = 1'b0;
        #1;
        check_val("post_rst_state", 32'(State), 32'd0);
        check_val("post_rst_outs", 32'(obs_outs()), 32'(exp_outs(4'd0)));
        check_val("aborted_rw", 32'(rw_cnt), 32'd0);
        return;
      end
      check_val("state", 32'(State), 32'(s));
      check_val("outs", 32'(obs_outs()), 32'(exp_outs(s)));
      check_val("mw_rw_overlap", 32'(MemWrite & RegWrite), 32'd0);
      check_val("pcw_pcwc_overlap", 32'(PCWrite & PCWriteCond), 32'd0);
      if (RegWrite) begin
        rw_cnt++;
        rw_stamps.push_back(cyc);
      end
      // Only Decode and MemAddr see the real opcode; elsewhere it is noise.
      Opcode = (s == 4'd1 || s == 4'd2) ? op : 6'($urandom);
      idx++;
      @(negedge clock); cyc++;
    end
    check_val("rw_count", 32'(rw_cnt), 32'(exp_regwrites(op)));
    check_val("latency_fetch", 32'(State), 32'd0);
    check_val("latency_len", 32'(idx), 32'(exp_len));
  endtask

  // ---------------- stimulus / scoreboard ----------------
  logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

  initial begin
    reset = 1'b1;
    Opcode = 6'b100011;
    repeat (3) @(negedge clock);
    #1;
    check_val("reset_state", 32'(State), 32'd0);
    check_val("reset_outs", 32'(obs_outs()), 32'd0);
    reset = 1'b0;
    #1;
    check_val("first_fetch", 32'(obs_outs()), 32'(exp_outs(4'd0)));

    // Directed: lw, R-type, sw, beq, j, illegal.
    run_instr(6'b100011, -1);
    run_instr(6'b000000, -1);
    run_instr(6'b101011, -1);
    run_instr(6'b000100, -1);
    run_instr(6'b000010, -1);
    run_instr(6'b111111, -1);

    // lw aborted by reset while in MemRd (step 3), then a clean lw.
    run_instr(6'b100011, 3);
    run_instr(6'b100011, -1);
    // Reset during Decode and during addi writeback.
    run_instr(6'b001000, 1);
    run_instr(6'b001000, 3);

    // Back-to-back addi: 32 RegWrite pulses four cycles apart.
    rw_stamps.delete();
    for (int i = 0; i < 32; i++) run_instr(6'b001000, -1);
    check_val("addi_pulses", 32'(rw_stamps.size()), 32'd32);
    for (int i = 1; i < rw_stamps.size(); i++)
      check_val("addi_spacing", 32'(rw_stamps[i] - rw_stamps[i-1]), 32'd4);

    // Random instruction mix, including arbitrary opcodes and occasional resets.
    for (int i = 0; i < 80; i++) begin
      int pick;
      logic [5:0] op;
      pick = $urandom_range(0, 7);
      op = (pick < 6) ? legal_ops[pick] : 6'($urandom_range(0, 63));
      run_instr(op, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
